// File: rtl/bj_pkg.sv
// Shared branch/jump opcode and 2-bit predictor counter encodings.
// Used by the resolve top and by the predictor table.
package bj_pkg;

    typedef enum logic [2:0] {
        BJ_BEQ  = 3'b000,
        BJ_BNE  = 3'b001,
        BJ_NONE = 3'b010,
        BJ_JUMP = 3'b011,
        BJ_BLT  = 3'b100,
        BJ_BGE  = 3'b101,
        BJ_BLTU = 3'b110,
        BJ_BGEU = 3'b111
    } bj_op_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = CTR_WNT;

    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        if (taken && (c != CTR_ST)) begin
            n = ctr_e'(c + 2'd1);
        end else if (!taken && (c != CTR_SNT)) begin
            n = ctr_e'(c - 2'd1);
        end
        return n;
    endfunction

    function automatic logic bj_is_cond(input bj_op_e op);
        return !((op == BJ_NONE) || (op == BJ_JUMP));
    endfunction

endpackage

// File: rtl/bht_table.sv
// Array of 2-bit saturating predictor counters, reset to weak-not-taken.
// Combinational read, one write per cycle; reads return the pre-write value.
module bht_table
    import bj_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output ctr_e             rd_ctr_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    ctr_e ctr_q [DEPTH];
    ctr_e wr_ctr_d;

    assign rd_ctr_o = ctr_q[rd_idx_i];
    assign wr_ctr_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolve with optional 2-bit predictor table (BRANCH_PREDICT_RESOLVE_BHT_EN).
// Without the table, PRED_TAKEN is 0 and every resolved-taken branch flushes.
module branch_predict_resolve
    import bj_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [XLEN-1:0]  IF_PC,
    output logic             PRED_TAKEN,
    input  logic             EX_VALID,
    input  logic [XLEN-1:0]  EX_PC,
    input  logic             EX_PRED_TAKEN,
    input  logic [2:0]       BRANCH_JUMP,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic             STALL,
    output logic             PC_SEL_OUT,
    output logic             FLUSH,
    output logic [CNT_W-1:0] MISPRED_CNT
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bj_op_e           op;
    logic             resolved_taken;
    logic             ex_fire;
    logic             mispred;
    logic             unused_bits;
    logic             pc_sel_q, pc_sel_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign op      = bj_op_e'(BRANCH_JUMP);
    assign ex_fire = EX_VALID & ~STALL;

    always_comb begin
        resolved_taken = 1'b0;
        case (op)
            BJ_BEQ:  resolved_taken = (DATA1 == DATA2);
            BJ_BNE:  resolved_taken = (DATA1 != DATA2);
            BJ_BLT:  resolved_taken = ($signed(DATA1) <  $signed(DATA2));
            BJ_BGE:  resolved_taken = ($signed(DATA1) >= $signed(DATA2));
            BJ_BLTU: resolved_taken = (DATA1 <  DATA2);
            BJ_BGEU: resolved_taken = (DATA1 >= DATA2);
            BJ_JUMP: resolved_taken = 1'b1;
            default: resolved_taken = 1'b0;
        endcase
    end

`ifdef BRANCH_PREDICT_RESOLVE_BHT_EN
    ctr_e rd_ctr;

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .rd_idx_i   (IF_PC[IDX_W+1:2]),
        .rd_ctr_o   (rd_ctr),
        .wr_en_i    (ex_fire & bj_is_cond(op)),
        .wr_idx_i   (EX_PC[IDX_W+1:2]),
        .wr_taken_i (resolved_taken)
    );

    assign PRED_TAKEN  = rd_ctr[1];
    assign mispred     = ex_fire & (resolved_taken != EX_PRED_TAKEN);
    assign unused_bits = ^{IF_PC, EX_PC, rd_ctr};
`else
    // No predictor: every fetch is predicted not-taken, so any taken branch mispredicts.
    assign PRED_TAKEN  = 1'b0;
    assign mispred     = ex_fire & resolved_taken;
    assign unused_bits = ^{IF_PC, EX_PC, EX_PRED_TAKEN, IDX_W[0]};
`endif

    always_comb begin
        pc_sel_d = pc_sel_q;
        flush_d  = flush_q;
        cnt_d    = cnt_q;
        if (!STALL) begin
            pc_sel_d = EX_VALID & resolved_taken;
            flush_d  = mispred;
            if (mispred && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_sel_q <= pc_sel_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PC_SEL_OUT  = pc_sel_q;
    assign FLUSH       = flush_q;
    assign MISPRED_CNT = cnt_q;

endmodule
